// File: rtl/keypad_scan.sv
// keypad_scan: scans a 3-column x 4-row telephone keypad. It debounces key
// presses and releases, and turns each accepted press into a one-cycle event
// for the downstream watch block.
//
// Ports
//   clk_i        system clock (1 kHz)
//   rst_i        asynchronous active-high reset
//   key_row_i    row sense, active-low, bit 0 = top row
//   key_col_o    column drive, active-low, exactly one bit low, bit 0 = left
//   num_input_o  last accepted digit 0-9, held until the next digit
//   num_valid_o  one-cycle strobe coincident with num_input_o updating
//   set_time_o   one-cycle strobe on '#'
//   clr_pulse_o  one-cycle strobe on '*'
//
// Optional feature: define KEYPAD_REPEAT_EN to re-emit num_valid_o every
// REPEAT_CNT cycles while a digit key stays held. Without it there is exactly
// one event per press.
//
// state     | meaning
// ----------+---------------------------------------------------------
// SCAN      | rotating columns, rows sampled on last cycle of each slot
// DEB_PRESS | column frozen, counting consecutive samples of same row
// HELD      | event emitted, waiting for a no-key sample
// DEB_REL   | counting consecutive no-key samples before rescanning

module keypad_scan #(
  parameter int SCAN_DIV   = 2,
  parameter int DEB_CNT    = 20,
  parameter int REPEAT_CNT = 250
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] key_row_i,
  output logic [2:0] key_col_o,
  output logic [3:0] num_input_o,
  output logic       num_valid_o,
  output logic       set_time_o,
  output logic       clr_pulse_o
);

  typedef enum logic [1:0] {
    S_SCAN      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_HELD      = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] DEB_TC   = 8'(DEB_CNT);

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [2:0] key_col_q, key_col_d;
  logic [7:0] div_q, div_d;
  logic [3:0] row_q, row_d;
  logic [7:0] deb_q, deb_d;
  logic [3:0] num_q, num_d;
  logic       valid_q, valid_d;
  logic       set_q, set_d;
  logic       clr_q, clr_d;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_LD = 16'(REPEAT_CNT);
  logic [15:0] rep_q, rep_d;
`endif

  logic [3:0] row_low;
  logic       one_low;
  logic [7:0] deb_inc;
  logic [1:0] col_next;
  logic       emit;
  logic [1:0] evt_ri;
  logic [3:0] evt_digit;
  logic       evt_star, evt_hash;

  // A sample is a key only when exactly one row is pulled low; ghosting
  // patterns with several rows low count as no key.
  assign row_low  = ~key_row_i;
  assign one_low  = (row_low != 4'd0) && ((row_low & (row_low - 4'd1)) == 4'd0);
  assign deb_inc  = (deb_q == 8'hFF) ? deb_q : deb_q + 8'd1;
  assign col_next = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;

  // Event decode uses row_d so a press accepted straight from SCAN
  // (DEB_CNT of 1) sees the row being latched this cycle.
  always_comb begin
    evt_ri = 2'd3;
    case (row_d)
      4'b1110: evt_ri = 2'd0;
      4'b1101: evt_ri = 2'd1;
      4'b1011: evt_ri = 2'd2;
      default: evt_ri = 2'd3;
    endcase
  end

  assign evt_star  = (evt_ri == 2'd3) && (col_q == 2'd0);
  assign evt_hash  = (evt_ri == 2'd3) && (col_q == 2'd2);
  assign evt_digit = (evt_ri == 2'd3) ? 4'd0
                   : 4'(evt_ri) * 4'd3 + 4'(col_q) + 4'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    div_d   = div_q;
    row_d   = row_q;
    deb_d   = deb_q;
    num_d   = num_q;
    valid_d = 1'b0;
    set_d   = 1'b0;
    clr_d   = 1'b0;
    emit    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif

    case (state_q)
      S_SCAN: begin
        if (div_q >= DIV_LAST) begin
          div_d = 8'd0;
          if (one_low) begin
            row_d = key_row_i;
            deb_d = 8'd1;
            if (DEB_TC <= 8'd1) begin
              state_d = S_HELD;
              emit    = 1'b1;
            end else begin
              state_d = S_DEB_PRESS;
            end
          end else begin
            col_d = col_next;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      S_DEB_PRESS: begin
        if (key_row_i == row_q) begin
          deb_d = deb_inc;
          if (deb_inc >= DEB_TC) begin
            state_d = S_HELD;
            emit    = 1'b1;
          end
        end else begin
          state_d = S_SCAN;
          col_d   = col_next;
          div_d   = 8'd0;
          deb_d   = 8'd0;
        end
      end

      S_HELD: begin
        if (!one_low) begin
          if (DEB_TC <= 8'd1) begin
            state_d = S_SCAN;
            col_d   = col_next;
            div_d   = 8'd0;
            deb_d   = 8'd0;
          end else begin
            state_d = S_DEB_REL;
            deb_d   = 8'd1;
          end
`ifdef KEYPAD_REPEAT_EN
          rep_d = 16'd0;
        end else if (rep_q != 16'd0) begin
          if (rep_q == 16'd1) begin
            valid_d = 1'b1;
            rep_d   = REP_LD;
          end else begin
            rep_d = rep_q - 16'd1;
          end
`endif
        end
      end

      S_DEB_REL: begin
        if (!one_low) begin
          deb_d = deb_inc;
          if (deb_inc >= DEB_TC) begin
            state_d = S_SCAN;
            col_d   = col_next;
            div_d   = 8'd0;
            deb_d   = 8'd0;
          end
        end else begin
          // Bounce during release: back to HELD without a new event.
          state_d = S_HELD;
          deb_d   = 8'd0;
        end
      end

      default: state_d = S_SCAN;
    endcase

    if (emit) begin
      if (evt_star) begin
        clr_d = 1'b1;
      end else if (evt_hash) begin
        set_d = 1'b1;
      end else begin
        num_d   = evt_digit;
        valid_d = 1'b1;
      end
`ifdef KEYPAD_REPEAT_EN
      rep_d = (evt_star || evt_hash) ? 16'd0 : REP_LD;
`endif
    end
  end

  always_comb begin
    key_col_d = 3'b110;
    case (col_d)
      2'd0:    key_col_d = 3'b110;
      2'd1:    key_col_d = 3'b101;
      2'd2:    key_col_d = 3'b011;
      default: key_col_d = 3'b110;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_SCAN;
      col_q     <= 2'd0;
      key_col_q <= 3'b110;
      div_q     <= 8'd0;
      row_q     <= 4'hF;
      deb_q     <= 8'd0;
      num_q     <= 4'd0;
      valid_q   <= 1'b0;
      set_q     <= 1'b0;
      clr_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      key_col_q <= key_col_d;
      div_q     <= div_d;
      row_q     <= row_d;
      deb_q     <= deb_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      set_q     <= set_d;
      clr_q     <= clr_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  assign key_col_o   = key_col_q;
  assign num_input_o = num_q;
  assign num_valid_o = valid_q;
  assign set_time_o  = set_q;
  assign clr_pulse_o = clr_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan. A physical keypad model turns a mask of
// pressed keys into row levels from the driven column; a monitor logs every
// event pulse, and each press is judged against the key map and the latency
// window implied by the scan and debounce timing.
module tb_keypad_scan;

  localparam int SD = 2;
  localparam int DB = 20;
`ifdef KEYPAD_REPEAT_EN
  localparam int RC      = 50;
  localparam int LONG    = 60;
  localparam int HOLDMAX = 65;
`else
  localparam int RC      = 250;
  localparam int LONG    = 100;
  localparam int HOLDMAX = 150;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_row;
  logic [2:0]  key_col;
  logic [3:0]  num_input;
  logic        num_valid, set_time, clr_pulse;
  logic [11:0] pressed = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ev_kind[$];
  int ev_dig[$];
  int ev_cyc[$];
  int last_digit = 0;
  string kmap = "123456789*0#";
  logic [3:0] prev_ni = 4'd0;

  keypad_scan #(.SCAN_DIV(SD), .DEB_CNT(DB), .REPEAT_CNT(RC)) dut (
    .clk_i(clk), .rst_i(rst), .key_row_i(key_row), .key_col_o(key_col),
    .num_input_o(num_input), .num_valid_o(num_valid),
    .set_time_o(set_time), .clr_pulse_o(clr_pulse));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Keypad physics: key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    key_row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !key_col[c]) key_row[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // 0 = digit, 1 = '#', 2 = '*'
  function automatic int key_kind(input int id);
    byte ch;
    ch = kmap[id];
    if (ch == "#") return 1;
    if (ch == "*") return 2;
    return 0;
  endfunction

  function automatic int key_digit(input int id);
    byte ch;
    ch = kmap[id];
    return int'(ch) - int'("0");
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_ni = 4'd0;
    end else begin
      check("col_onehot", 32'((key_col == 3'b110) || (key_col == 3'b101) || (key_col == 3'b011)), 1);
      check("single_pulse", 32'(!((num_valid & set_time) | (num_valid & clr_pulse) | (set_time & clr_pulse))), 1);
      check("ni_with_valid", 32'((num_input == prev_ni) || num_valid), 1);
      prev_ni = num_input;
      if (num_valid) begin ev_kind.push_back(0); ev_dig.push_back(int'(num_input)); ev_cyc.push_back(cyc); end
      if (set_time)  begin ev_kind.push_back(1); ev_dig.push_back(-1); ev_cyc.push_back(cyc); end
      if (clr_pulse) begin ev_kind.push_back(2); ev_dig.push_back(-1); ev_cyc.push_back(cyc); end
    end
  end

  task automatic clear_events();
    ev_kind.delete(); ev_dig.delete(); ev_cyc.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_col"}, 32'(key_col), 32'(3'b110));
    check({tag, "_num"}, 32'(num_input), 0);
    check({tag, "_pulses"}, 32'({num_valid, set_time, clr_pulse}), 0);
  endtask

  // Check the single event logged for key id, and optional latency window.
  task automatic judge(input string tag, input int id, input int p, input bit win);
    check({tag, "_count"}, ev_kind.size(), 1);
    if (ev_kind.size() >= 1) begin
      check({tag, "_kind"}, ev_kind[0], key_kind(id));
      if (key_kind(id) == 0) begin
        check({tag, "_digit"}, ev_dig[0], key_digit(id));
        last_digit = key_digit(id);
      end
      if (win)
        check({tag, "_window"}, 32'((ev_cyc[0] >= p + DB) && (ev_cyc[0] <= p + 3*SD + DB - 1)), 1);
    end
    check({tag, "_num_hold"}, 32'(num_input), last_digit);
  endtask

  task automatic do_press(input int id, input int hold, input int rel, input string tag);
    int p;
    clear_events();
    @(posedge clk); #1;
    p = cyc;
    pressed = 12'(1) << id;
    wait_cycles(hold);
    pressed = '0;
    wait_cycles(rel);
    judge(tag, id, p, 1'b1);
  endtask

  // Release reset with a key of column col already held; from reset the scan
  // reaches column col's sample on cycle (col+1)*SD, and the event follows
  // DB-1 edges later.
  task automatic release_reset_expect(input int col, input string tag);
    int r;
    @(posedge clk); #1;
    clear_events();
    rst = 1'b0;
    r = cyc;
    wait_cycles((col + 1) * SD + DB + 5);
    check({tag, "_count"}, ev_kind.size(), 1);
    if (ev_kind.size() >= 1)
      check({tag, "_latency"}, ev_cyc[0], r + (col + 1) * SD + DB - 1);
    check({tag, "_num"}, 32'(num_input), 5);
  endtask

  initial begin
    int id, hold, rel;
    logic [2:0] seen;

    rst = 1'b1;
    wait_cycles(3);
    check_reset_values("reset");
    rst = 1'b0;
    wait_cycles(5);

    // clean press of 5
    do_press(4, LONG, 60, "press5");

    // bounce: two short bursts separated by one high cycle, then steady hold
    clear_events();
    pressed = 12'(1) << 7;
    wait_cycles(DB - 1);
    pressed = '0;
    wait_cycles(1);
    pressed = 12'(1) << 7;
    wait_cycles(DB - 1);
    check("bounce_none", ev_kind.size(), 0);
    wait_cycles(LONG - DB);
    pressed = '0;
    wait_cycles(60);
    judge("bounce_hold", 7, 0, 1'b0);

    // 0, then '#', then '*'
    do_press(10, 60, 40, "key0");
    do_press(11, 60, 40, "hash");
    do_press(9, 60, 40, "star");

    // ghost: rows 0 and 2 low on column 0
    clear_events();
    seen = 3'b000;
    pressed = (12'(1) << 0) | (12'(1) << 6);
    for (int i = 0; i < 12 * SD; i++) begin
      wait_cycles(1);
      seen = seen | ~key_col;
    end
    wait_cycles(40);
    check("ghost_none", ev_kind.size(), 0);
    check("ghost_rotate", 32'(seen), 32'(3'b111));
    pressed = '0;
    wait_cycles(10);

    // reset in DEB_PRESS, then in HELD, key 5 held throughout
    do_press(4, 60, 40, "press5b");
    pressed = 12'(1) << 4;
    wait_cycles(3 * SD + 6);
    rst = 1'b1;
    #1;
    check_reset_values("rst_deb");
    wait_cycles(2);
    release_reset_expect(1, "redetect1");
    wait_cycles(10);
    rst = 1'b1;
    #1;
    check_reset_values("rst_held");
    wait_cycles(2);
    release_reset_expect(1, "redetect2");
    pressed = '0;
    wait_cycles(60);
    check("after_rst_count", ev_kind.size(), 1);
    last_digit = 5;

    // randomized presses
    for (int n = 0; n < 12; n++) begin
      id   = $urandom_range(0, 11);
      hold = $urandom_range(3 * SD + DB + 5, HOLDMAX);
      rel  = $urandom_range(DB + 5, 60);
      do_press(id, hold, rel, $sformatf("rand%0d", n));
    end

`ifdef KEYPAD_REPEAT_EN
    clear_events();
    pressed = 12'(1) << 6;
    wait_cycles(3 * SD + DB + 210);
    pressed = '0;
    wait_cycles(60);
    check("repeat7_count", ev_kind.size(), 5);
    foreach (ev_dig[k]) check("repeat7_digit", ev_dig[k], 7);
    clear_events();
    pressed = 12'(1) << 11;
    wait_cycles(3 * SD + DB + 210);
    pressed = '0;
    wait_cycles(60);
    check("repeat_hash_count", ev_kind.size(), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 3-column × 4-row telephone-style matrix keypad, debounces key presses, and converts each press into a single-cycle event. It sits directly upstream of the `watch` clock block. It drives that block's `set_time` and `num_input` inputs, and adds a `num_valid` strobe so that digit 0 is usable. It runs on the same 1 kHz system clock.

## Interface
- `SCAN_DIV`, default 2: clock cycles each column is driven. Minimum 2.
- `DEB_CNT`, default 20: consecutive identical samples required for press/release (20 ms at 1 kHz). Range 1–255.
- `REPEAT_CNT`, default 250: cycles between auto-repeat events. Used only when `KEYPAD_REPEAT_EN` is defined.

- `clk` input 1: system clock, 1 kHz.
- `rst` input 1: asynchronous, active-high reset.
- `key_row` input 4: row sense, active-low, external pull-ups. Bit 0 is the top row.
- `key_col` output 3: column drive, active-low. Exactly one bit is low at any time. Bit 0 is the left column.
- `num_input` output 4: last accepted digit, 0–9. Holds until the next digit.
- `num_valid` output 1: one-cycle pulse, coincident with `num_input` updating.
- `set_time` output 1: one-cycle pulse on `#`.
- `clr_pulse` output 1: one-cycle pulse on `*`.

## Operation
- Key map, listed top row to bottom:
  - col0: 1, 4, 7, `*`
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, `#`
- Column rotation in SCAN: col0 → col1 → col2 → col0, advancing every `SCAN_DIV` cycles.
- Row sampling: rows are sampled on the last cycle of each column slot only. This gives one cycle of settle time.
- Valid sample: exactly one `key_row` bit is low. Zero low bits or two or more low bits are treated as "no key".
- FSM states:
  - **SCAN**: rotating columns. A valid sample latches the column and row, freezes `key_col`, and moves to DEB_PRESS with `deb_cnt`=1.
  - **DEB_PRESS**: samples every cycle.
    - Same row alone still low: `deb_cnt`++.
    - On reaching `DEB_CNT`: move to HELD and emit the event.
    - Any other sample: return to SCAN, resume rotation from the next column, no event.
  - **HELD**: waits for release. A sample with no key pressed moves to DEB_REL with `deb_cnt`=1. Any other row combination is ignored (no new event).
  - **DEB_REL**:
    - Consecutive no-key samples: `deb_cnt`++.
    - On reaching `DEB_CNT`: return to SCAN.
    - Any key sample: return to HELD.
- Event on HELD entry:
  - Digit: `num_input` ← digit, `num_valid`=1 for one cycle.
  - `#`: `set_time`=1 for one cycle; `num_input` unchanged.
  - `*`: `clr_pulse`=1 for one cycle; `num_input` unchanged.
- At most one event pulse is asserted in any cycle.
- `deb_cnt` is 8 bits and saturates. It never wraps.
- Asserting `rst` mid-press forces SCAN. A key still held after reset is re-debounced and produces one fresh event.

## Timing
- Reset values:
  - `key_col`=3'b110
  - `num_input`=4'd0
  - `num_valid`=0, `set_time`=0, `clr_pulse`=0
  - State SCAN, column 0, counters 0
- Press latency: the event pulse is registered and occurs `DEB_CNT` cycles after the detecting SCAN sample (the `DEB_CNT`th consecutive good sample, counting the detecting sample, plus one register stage).
- Worst-case detection delay from a clean press to the detecting sample: 3×`SCAN_DIV` cycles.
- Release: `DEB_CNT` cycles of no key before returning to SCAN. The next press can be detected on the following sample slot.
- All outputs are registered. There are no combinational paths from `key_row` to any output.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - While in HELD with a digit key, a repeat counter reloads on HELD entry.
  - Every `REPEAT_CNT` cycles it re-emits `num_valid` with the same `num_input`.
  - `#` and `*` never repeat.
  - Leaving HELD (to DEB_REL) stops and clears the counter. Returning to HELD from DEB_REL does not reload it and does not emit.
- `KEYPAD_REPEAT_EN` undefined: no repeat logic is present. Exactly one event per press.

## Test plan
- **Clean press of 5** (col1, row1 low for 100 cycles, then release): exactly one `num_valid` pulse with `num_input`=5. `num_input` still equals 5 after release. No other pulses.
- **Bounce rejection**: row low for `DEB_CNT`−1 cycles, high for 1, low for `DEB_CNT`−1 → no event. Then hold steady → one event.
- **Digit 0, then `#`, then `*`**:
  - 0: `num_valid` with `num_input`=0.
  - `#`: `set_time` pulse only.
  - `*`: `clr_pulse` pulse only. `num_input` stays 0.
- **Ghost rejection**: rows 0 and 2 both low on col0 → no event. `key_col` keeps rotating.
- **Reset mid-press**: assert `rst` during DEB_PRESS and again during HELD → outputs return to reset values immediately. A key still held after reset yields one event `DEB_CNT` cycles after redetection.
- **Auto-repeat** (`KEYPAD_REPEAT_EN`, `REPEAT_CNT`=50): hold 7 for 200 cycles after the event → 1 + 4 `num_valid` pulses, all with `num_input`=7. Hold `#` → a single `set_time` pulse.
